att_sched: RTL and testbench

ATT_SCHED -- requirements
Module: att_sched

---
 rtl/att_pkg.sv | 18 +
 rtl/att_shift_out.sv | 66 ++++++
 rtl/att_sched.sv | 128 ++++++++++++
 tb/tb_att_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/att_pkg.sv
// Shared constants and FSM state encoding for the attenuator update scheduler.
package att_pkg;

  localparam int ATT_WIDTH = 16;
  localparam int NUM_REQ   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LATCH  = 2'd2,
    ST_SETTLE = 2'd3
  } att_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/att_shift_out.sv
// Serialises one attenuator word LSB first; each bit spends CLK_DIV cycles
// with SCLK low and CLK_DIV cycles with SCLK high while SI holds the bit.
module att_shift_out
  import att_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [ATT_WIDTH-1:0] word,
  output logic                 SI,
  output logic                 SCLK,
  output logic                 shift_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(ATT_WIDTH);

  logic                 active;
  logic                 phase;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [ATT_WIDTH-1:0] sh_word;
  logic                 div_last;
  logic                 bit_last;

  assign div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last   = (bit_cnt == BIT_W'(ATT_WIDTH - 1));
  assign SI         = active & sh_word[0];
  assign SCLK       = active & phase;
  assign shift_done = active & phase & div_last & bit_last;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh_word <= '0;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh_word <= word;
    end else if (active) begin
      if (div_last) begin
        div_cnt <= '0;
        phase   <= ~phase;
        // End of the SCLK-high half: advance to the next bit.
        if (phase) begin
          sh_word <= sh_word >> 1;
          if (bit_last) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/att_sched.sv
// Round-robin scheduler for two attenuator-word requesters: skips redundant
// words, otherwise shifts, latches and waits out the attenuator settle time.
module att_sched
  import att_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int SETTLE_CYC = 4000
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [ATT_WIDTH-1:0] data0,
  input  logic [ATT_WIDTH-1:0] data1,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 done,
  output logic [ATT_WIDTH-1:0] last_word,
  output logic                 SI,
  output logic                 SCLK,
  output logic                 LE,
  output att_state_t           state_dbg
);

  localparam int CNT_MAX = max2(CLK_DIV, SETTLE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Handshake: a requester holds req[i] high with its data stable; the cycle
  // gnt[i] is high is the accept cycle and the data is captured on that edge.
  att_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 prio;
  logic                 last_valid;
  logic                 skip_done;
  logic [ATT_WIDTH-1:0] cap_word;

  logic [NUM_REQ-1:0]   gnt_sel;
  logic [ATT_WIDTH-1:0] sel_word;
  logic                 can_grant;
  logic                 skip;
  logic                 start;
  logic                 latch_last;
  logic                 settle_last;
  logic                 shift_done;

  always_comb begin
    gnt_sel = req;
    if (req == 2'b11) begin
      gnt_sel = prio ? 2'b10 : 2'b01;
    end
  end

  // No grant in the skip-done cycle so a held request waits one cycle.
  assign can_grant   = (state == ST_IDLE) && !skip_done && !areset;
  assign gnt         = can_grant ? gnt_sel : 2'b00;
  assign sel_word    = gnt[1] ? data1 : data0;
  assign skip        = (gnt != 2'b00) && last_valid && (sel_word == last_word);
  assign start       = (gnt != 2'b00) && !skip;
  assign latch_last  = (cnt == CNT_W'(CLK_DIV - 1));
  assign settle_last = (cnt == CNT_W'(SETTLE_CYC - 1));

  assign busy      = (state != ST_IDLE);
  assign LE        = (state == ST_LATCH);
  assign done      = skip_done | ((state == ST_SETTLE) && settle_last);
  assign state_dbg = state;

  att_shift_out #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .word      (sel_word),
    .SI        (SI),
    .SCLK      (SCLK),
    .shift_done(shift_done)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prio       <= 1'b0;
      last_valid <= 1'b0;
      skip_done  <= 1'b0;
      cap_word   <= '0;
      last_word  <= '0;
    end else begin
      skip_done <= skip;
      if (gnt != 2'b00) begin
        prio     <= gnt[0];
        cap_word <= sel_word;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            state <= ST_LATCH;
            cnt   <= '0;
          end
        end
        ST_LATCH: begin
          if (latch_last) begin
            // LE falls here: the attenuator now holds cap_word.
            state      <= ST_SETTLE;
            cnt        <= '0;
            last_word  <= cap_word;
            last_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_att_sched.sv
// Directed bench: default-parameter instance for the long sequences, a
// CLK_DIV=1/SETTLE_CYC=1 instance driven from a vector table.
module tb_att_sched;
  import att_pkg::*;

  localparam int D0 = 5;
  localparam int S0 = 4000;
  localparam int LAT0 = 33 * D0 + S0;
  localparam int D1 = 1;
  localparam int S1 = 1;
  localparam int LAT1 = 33 * D1 + S1;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  req0, req1;
  logic [15:0] d00, d01, d10, d11;
  logic [1:0]  gnt0, gnt1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] lw0, lw1;
  logic        si0, si1, sclk0, sclk1, le0, le1;
  att_state_t  st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  att_sched #(.CLK_DIV(D0), .SETTLE_CYC(S0)) u0 (
    .aclk(aclk), .areset(areset), .req(req0), .data0(d00), .data1(d01),
    .gnt(gnt0), .busy(busy0), .done(done0), .last_word(lw0),
    .SI(si0), .SCLK(sclk0), .LE(le0), .state_dbg(st0)
  );

  att_sched #(.CLK_DIV(D1), .SETTLE_CYC(S1)) u1 (
    .aclk(aclk), .areset(areset), .req(req1), .data0(d10), .data1(d11),
    .gnt(gnt1), .busy(busy1), .done(done1), .last_word(lw1),
    .SI(si1), .SCLK(sclk1), .LE(le1), .state_dbg(st1)
  );

  // Monitor view of whichever instance the current sequence drives.
  bit          mon_sel;
  logic [1:0]  m_gnt;
  logic        m_busy, m_done, m_si, m_sclk, m_le;
  logic [15:0] m_lw;
  assign m_gnt  = mon_sel ? gnt1  : gnt0;
  assign m_busy = mon_sel ? busy1 : busy0;
  assign m_done = mon_sel ? done1 : done0;
  assign m_si   = mon_sel ? si1   : si0;
  assign m_sclk = mon_sel ? sclk1 : sclk0;
  assign m_le   = mon_sel ? le1   : le0;
  assign m_lw   = mon_sel ? lw1   : lw0;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  exp_gnt;
    bit          skip;
    logic [15:0] word;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
    if (sel) begin
      req1 = r; d10 = a; d11 = b;
    end else begin
      req0 = r; d00 = a; d01 = b;
    end
  endtask

  // One request through to done, with serial-line, LE and busy monitoring.
  task automatic run_xfer(input bit sel, input logic [1:0] r, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] exp_gnt, input bit exp_skip,
                          input logic [15:0] exp_word, input int exp_lat, input int gnt_wait,
                          input bit hold, input string name);
    int waited, lat, edges, le_cyc, hi_run, max_run, busy_bad, si_bad, div;
    logic [15:0] capt;
    logic prev_sclk, prev_si;
    div = sel ? D1 : D0;
    mon_sel = sel;
    @(negedge aclk);
    set_req(sel, r, a, b);
    #1;
    waited = 0;
    while (m_gnt == 2'b00 && waited < gnt_wait) begin
      @(negedge aclk);
      #1;
      waited++;
    end
    check({name, "_gnt"}, 32'(m_gnt), 32'(exp_gnt));
    lat = 0; edges = 0; le_cyc = 0; hi_run = 0; max_run = 0;
    busy_bad = 0; si_bad = 0; capt = '0;
    prev_sclk = m_sclk; prev_si = m_si;
    while (lat < exp_lat + 20) begin
      @(negedge aclk);
      if (lat == 0 && !hold) set_req(sel, 2'b00, a, b);
      #1;
      lat++;
      if (m_sclk && !prev_sclk) begin
        capt = {m_si, capt[15:1]};
        edges++;
      end
      if (m_sclk && prev_sclk && (m_si != prev_si)) si_bad++;
      hi_run = m_sclk ? hi_run + 1 : 0;
      if (hi_run > max_run) max_run = hi_run;
      if (m_le) le_cyc++;
      if (m_busy !== !exp_skip) busy_bad++;
      prev_sclk = m_sclk;
      prev_si = m_si;
      if (m_done) break;
    end
    check({name, "_done_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy"}, 32'(busy_bad), 32'd0);
    check({name, "_last_word"}, 32'(m_lw), 32'(exp_word));
    if (exp_skip) begin
      check({name, "_skip_edges"}, 32'(edges + le_cyc), 32'd0);
    end else begin
      check({name, "_sclk_edges"}, 32'(edges), 32'd16);
      check({name, "_si_word"}, 32'(capt), 32'(exp_word));
      check({name, "_le_cycles"}, 32'(le_cyc), 32'(div));
      check({name, "_sclk_high"}, 32'(max_run), 32'(div));
      check({name, "_si_stable"}, 32'(si_bad), 32'd0);
    end
  endtask

  initial begin
    int k, gnt_bad, done_cnt;
    tbl[0] = '{2'b01, 16'hFFFF, 16'h0000, 2'b01, 1'b0, 16'hFFFF};
    tbl[1] = '{2'b10, 16'h0000, 16'hFFFF, 2'b10, 1'b1, 16'hFFFF};
    tbl[2] = '{2'b11, 16'hA5C3, 16'h1234, 2'b01, 1'b0, 16'hA5C3};
    tbl[3] = '{2'b11, 16'hA5C3, 16'h1234, 2'b10, 1'b0, 16'h1234};
    tbl[4] = '{2'b10, 16'h0000, 16'h1234, 2'b10, 1'b1, 16'h1234};
    tbl[5] = '{2'b11, 16'h0000, 16'h1234, 2'b01, 1'b0, 16'h0000};
    tbl[6] = '{2'b01, 16'h0000, 16'h5555, 2'b01, 1'b1, 16'h0000};
    tbl[7] = '{2'b11, 16'h8001, 16'h0000, 2'b10, 1'b1, 16'h0000};

    // Reset state, including grant suppression while reset is held.
    areset = 1'b1;
    mon_sel = 1'b0;
    set_req(1'b0, 2'b01, 16'h0378, 16'h0000);
    set_req(1'b1, 2'b11, 16'h0001, 16'h0002);
    repeat (2) @(negedge aclk);
    #1;
    check("rst_gnt", {30'd0, gnt0 | gnt1}, 32'd0);
    check("rst_outs0", {27'd0, si0, sclk0, le0, busy0, done0}, 32'd0);
    check("rst_outs1", {27'd0, si1, sclk1, le1, busy1, done1}, 32'd0);
    check("rst_last_word", {lw0, lw1}, 32'd0);
    set_req(1'b0, 2'b00, 16'h0000, 16'h0000);
    set_req(1'b1, 2'b00, 16'h0000, 16'h0000);
    @(negedge aclk);
    areset = 1'b0;

    // Fast instance: table of arbitration / skip vectors.
    for (int i = 0; i < 8; i++) begin
      run_xfer(1'b1, tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].exp_gnt, tbl[i].skip,
               tbl[i].word, tbl[i].skip ? 1 : LAT1, 3, 1'b0, $sformatf("vec%0d", i));
    end

    // Both requests held: 01, 10, 01 back to back, each the cycle after done.
    run_xfer(1'b0, 2'b11, 16'h1111, 16'h2222, 2'b01, 1'b0, 16'h1111, LAT0, 3, 1'b1, "rr_a");
    run_xfer(1'b0, 2'b11, 16'h1111, 16'h2222, 2'b10, 1'b0, 16'h2222, LAT0, 0, 1'b1, "rr_b");
    run_xfer(1'b0, 2'b11, 16'h1111, 16'h2222, 2'b01, 1'b0, 16'h1111, LAT0, 0, 1'b0, "rr_c");

    // Reset pulse during SHIFT bit 7 aborts the transfer.
    mon_sel = 1'b0;
    @(negedge aclk);
    set_req(1'b0, 2'b01, 16'h0378, 16'h0000);
    #1;
    check("abort_gnt", 32'(gnt0), 32'd1);
    for (k = 1; k <= 75; k++) begin
      @(negedge aclk);
      if (k == 1) set_req(1'b0, 2'b00, 16'h0378, 16'h0000);
    end
    #1;
    check("abort_pre_busy", 32'(busy0), 32'd1);
    areset = 1'b1;
    #1;
    check("abort_outs", {28'd0, si0, sclk0, le0, busy0}, 32'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    #1;
    check("abort_last_word", 32'(lw0), 32'd0);
    done_cnt = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge aclk);
      #1;
      if (done0) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_xfer(1'b0, 2'b01, 16'h0378, 16'h0000, 2'b01, 1'b0, 16'h0378, LAT0, 3, 1'b0, "full_0378");
    // First word after reset equals the reset last_word but must still go out.
    run_xfer(1'b1, 2'b01, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0000, LAT1, 3, 1'b0, "first_zero");

    // Repeat of the same word is skipped.
    run_xfer(1'b0, 2'b01, 16'h0378, 16'h0000, 2'b01, 1'b1, 16'h0378, 1, 3, 1'b0, "skip_0378");

    // Requester 1 arrives during SETTLE and waits for done.
    mon_sel = 1'b0;
    @(negedge aclk);
    set_req(1'b0, 2'b01, 16'h4444, 16'h0000);
    #1;
    check("settle_gnt0", 32'(gnt0), 32'd1);
    gnt_bad = 0;
    k = 0;
    while (k < LAT0 + 20) begin
      @(negedge aclk);
      if (k == 0) set_req(1'b0, 2'b00, 16'h4444, 16'h0000);
      if (k == 1000) set_req(1'b0, 2'b10, 16'h4444, 16'h5555);
      #1;
      k++;
      if (gnt0 != 2'b00) gnt_bad++;
      if (done0) break;
    end
    check("settle_done_lat", 32'(k), 32'(LAT0));
    check("settle_no_gnt", 32'(gnt_bad), 32'd0);
    run_xfer(1'b0, 2'b10, 16'h4444, 16'h5555, 2'b10, 1'b0, 16'h5555, LAT0, 0, 1'b0, "settle_req1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
